calc3_core: RTL and testbench
=============================

CALC3_CORE -- requirements
Module: calc3_core

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of request/response ports (2..8).
REQ-002 Parameter DATA_W, default 32, operand/result width (power of two, 8..64).
REQ-003 Parameter TAG_W, default 2, tag width.
REQ-004 Parameter QDEPTH, default 2, per-port command FIFO depth (power of two, 1..8).
REQ-005 Clocking SHALL be: one clock; reset is synchronous and active-low.
REQ-006 c_clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-low; low at a c_clk edge clears all state.
REQ-008 req_cmd_in  in  NUM_PORTS*4  per-port command; port p in bits [4p+3:4p].
REQ-009 req_data_in  in  NUM_PORTS*DATA_W  per-port operand bus; carries data1 in the command cycle and data2 in the next cycle.
REQ-010 req_tag_in  in  NUM_PORTS*TAG_W  per-port tag, sampled in the command cycle.
REQ-011 req_busy  out  NUM_PORTS  per-port FIFO full.
REQ-012 out_resp  out  NUM_PORTS*2  per-port response: 00 none, 01 success, 10 overflow/underflow/invalid.
REQ-013 out_data  out  NUM_PORTS*DATA_W  per-port result.
REQ-014 out_tag  out  NUM_PORTS*TAG_W  per-port echoed tag.

Function
REQ-015 Command codes SHALL be: 0000 nop, 0001 add, 0010 sub, 0101 shift left, 0110 shift right; every other nonzero code is invalid.
REQ-016 Each port SHALL run a capture FSM: IDLE -> WAIT_D2 on nonzero cmd with req_busy=0; WAIT_D2 -> IDLE unconditionally, writing {cmd,tag,data1,data2} to the port FIFO.
REQ-017 A nonzero cmd in IDLE while req_busy=1 SHALL be dropped with no response.
REQ-018 A cmd seen in WAIT_D2 SHALL be ignored.
REQ-019 req_busy SHALL count entries in flight, including a WAIT_D2 capture, against QDEPTH.
REQ-020 Add/sub/invalid heads SHALL go to the add unit; shift heads SHALL go to the shift unit; each unit grants at most one port per cycle.
REQ-021 Each unit SHALL use an independent round-robin pointer: the search starts at pointer, and after a grant the pointer becomes granted port+1 mod NUM_PORTS.
REQ-022 Add: an unsigned carry out of DATA_W bits SHALL give resp 10 and data 0; otherwise resp 01 and the sum.
REQ-023 Sub: data2>data1 SHALL give resp 10 and data 0; otherwise resp 01 and the difference.
REQ-024 Shift SHALL be logical by data2[log2(DATA_W)-1:0], with upper bits ignored, and SHALL always return resp 01.
REQ-025 An invalid code SHALL give resp 10 and data 0.
REQ-026 Latency: cmd at cycle t, data2 at t+1, FIFO entry visible at t+2, grant at t+2 if uncontested, response on outputs for exactly one cycle at t+3.
REQ-027 Each FIFO SHALL pop on grant; a simultaneous push and pop on a full FIFO SHALL be legal, with the count unchanged.
REQ-028 Responses from one port SHALL return in that port's command order.
REQ-029 out_data and out_tag SHALL be 0 whenever out_resp=00.

Reset
REQ-030 On reset low, FSMs SHALL go to IDLE, FIFOs SHALL empty, pointers SHALL be 0, and all outputs SHALL be 0, at the next edge.
REQ-031 Commands in flight at reset SHALL be discarded without responses; mid-WAIT_D2 captures SHALL be abandoned.

Structure
REQ-032 Package calc3_pkg SHALL hold the cmd and resp code constants and the FIFO entry struct {cmd,tag,data1,data2}.
REQ-033 Sub-module calc3_port_fifo SHALL hold the per-port FSM and FIFO (parameters DATA_W, TAG_W, QDEPTH) and SHALL be instantiated NUM_PORTS times.

Verification
REQ-034 Port0 add 0x00000005+0x00000007, tag 1 -> at t+3 port0 resp 01, data 0x0000000C, tag 1.
REQ-035 Port1 add 0xFFFFFFFF+0x00000001 -> resp 10, data 0; port2 sub 3-5 -> resp 10, data 0.
REQ-036 All 4 ports issue add in the same cycle -> responses at t+3..t+6 in order 0,1,2,3; repeating this immediately -> order 0,1,2,3 again (pointer wrap).
REQ-037 Port3 shift left 0x1 by 0x00000024 -> data 0x00000010; concurrent port0 add -> both respond in the same cycle.
REQ-038 QDEPTH=2, port0 issues 3 adds while shift traffic blocks nothing and add unit is held by other ports -> third dropped, req_busy high; reset low mid-burst -> all outputs 0, no later responses.

Source files
------------

// File: rtl/calc3_pkg.sv
// Shared command/response codes and the per-port FIFO entry layout for calc3_core.
package calc3_pkg;

  localparam logic [3:0] CmdNop = 4'b0000;
  localparam logic [3:0] CmdAdd = 4'b0001;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdShl = 4'b0101;
  localparam logic [3:0] CmdShr = 4'b0110;

  localparam logic [1:0] RespNone = 2'b00;
  localparam logic [1:0] RespOk   = 2'b01;
  localparam logic [1:0] RespErr  = 2'b10;

  // Entry fields are sized for the widest legal configuration; narrower
  // instances use the low bits only.
  localparam int unsigned MaxDataW = 64;
  localparam int unsigned MaxTagW  = 8;

  typedef struct packed {
    logic [3:0]          cmd;
    logic [MaxTagW-1:0]  tag;
    logic [MaxDataW-1:0] data1;
    logic [MaxDataW-1:0] data2;
  } fifo_entry_t;

  function automatic logic is_shift(input logic [3:0] cmd);
    return (cmd == CmdShl) || (cmd == CmdShr);
  endfunction

endpackage

// File: rtl/calc3_port_fifo.sv
// Per-port two-cycle command capture FSM feeding a small command FIFO.
module calc3_port_fifo
  import calc3_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 2,
  parameter int unsigned QDEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [3:0]        cmd_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              pop_i,
  output logic              busy_o,
  output logic              head_valid_o,
  output fifo_entry_t       head_o
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  typedef enum logic [0:0] {StIdle, StWaitD2} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cmd_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] data1_q;
  fifo_entry_t       mem_q [QDEPTH];
  fifo_entry_t       wr_entry;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              accept, push;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(QDEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  // A capture waiting for data2 already owns a slot, so it counts toward fullness.
  assign busy_o = (32'(count_q) + ((state_q == StWaitD2) ? 32'd1 : 32'd0)) >= QDEPTH;
  assign head_valid_o = (count_q != '0);
  assign head_o = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    push    = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_i != CmdNop && !busy_o) begin
          accept  = 1'b1;
          state_d = StWaitD2;
        end
      end
      StWaitD2: begin
        push    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_entry                    = '0;
    wr_entry.cmd                = cmd_q;
    wr_entry.tag[TAG_W-1:0]     = tag_q;
    wr_entry.data1[DATA_W-1:0]  = data1_q;
    wr_entry.data2[DATA_W-1:0]  = data_i;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cmd_q    <= '0;
      tag_q    <= '0;
      data1_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        cmd_q   <= cmd_i;
        tag_q   <= tag_i;
        data1_q <= data_i;
      end
      if (push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: rtl/calc3_core.sv
// Multi-port add/sub/shift calculator: per-port command FIFOs served by an add unit and a
// shift unit, each with its own round-robin arbiter; one-cycle registered responses.
module calc3_core
  import calc3_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TAG_W     = 2,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*4-1:0]        req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
  input  logic [NUM_PORTS*TAG_W-1:0]    req_tag_in,
  output logic [NUM_PORTS-1:0]          req_busy,
  output logic [NUM_PORTS*2-1:0]        out_resp,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  output logic [NUM_PORTS*TAG_W-1:0]    out_tag
);

  localparam int unsigned PtrW = $clog2(NUM_PORTS);
  localparam int unsigned ShW  = $clog2(DATA_W);

  fifo_entry_t            head [NUM_PORTS];
  logic [NUM_PORTS-1:0]   head_valid, pop, add_req, shf_req;
  logic [PtrW-1:0]        add_ptr_q, shf_ptr_q;
  logic [PtrW:0]          add_pick, shf_pick;
  logic                   add_gnt, shf_gnt;
  logic [PtrW-1:0]        add_idx, shf_idx;
  fifo_entry_t            add_e, shf_e;
  logic [DATA_W-1:0]      a1, a2, s1;
  logic [ShW-1:0]         shamt;
  logic [DATA_W:0]        sum;
  logic [1:0]             add_resp;
  logic [DATA_W-1:0]      add_data, shf_data;
  logic [1:0]             resp_q [NUM_PORTS];
  logic [DATA_W-1:0]      data_q [NUM_PORTS];
  logic [TAG_W-1:0]       tag_q  [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc3_port_fifo #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .QDEPTH (QDEPTH)
    ) u_fifo (
      .clk_i        (c_clk),
      .rst_ni       (reset),
      .cmd_i        (req_cmd_in[4*p +: 4]),
      .data_i       (req_data_in[DATA_W*p +: DATA_W]),
      .tag_i        (req_tag_in[TAG_W*p +: TAG_W]),
      .pop_i        (pop[p]),
      .busy_o       (req_busy[p]),
      .head_valid_o (head_valid[p]),
      .head_o       (head[p])
    );

    assign shf_req[p] = head_valid[p] && is_shift(head[p].cmd);
    assign add_req[p] = head_valid[p] && !is_shift(head[p].cmd);

    assign out_resp[2*p +: 2]           = resp_q[p];
    assign out_data[DATA_W*p +: DATA_W] = data_q[p];
    assign out_tag[TAG_W*p +: TAG_W]    = tag_q[p];
  end

  // Returns {found, index}; scanning from the far end lets the port nearest the pointer win.
  function automatic logic [PtrW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                            input logic [PtrW-1:0]      ptr);
    logic [PtrW:0] res;
    int unsigned   j;
    res = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = 32'(ptr) + 32'(i);
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (req[j]) res = {1'b1, PtrW'(j)};
    end
    return res;
  endfunction

  function automatic logic [PtrW-1:0] ptr_after(input logic [PtrW-1:0] idx);
    return (idx == PtrW'(NUM_PORTS - 1)) ? '0 : idx + PtrW'(1);
  endfunction

  always_comb begin
    add_pick = rr_pick(add_req, add_ptr_q);
    shf_pick = rr_pick(shf_req, shf_ptr_q);
    add_gnt  = add_pick[PtrW];
    add_idx  = add_pick[PtrW-1:0];
    shf_gnt  = shf_pick[PtrW];
    shf_idx  = shf_pick[PtrW-1:0];
    pop      = '0;
    if (add_gnt) pop[add_idx] = 1'b1;
    if (shf_gnt) pop[shf_idx] = 1'b1;
  end

  // Add unit: add, sub and every invalid code land here.
  always_comb begin
    add_e    = head[add_idx];
    a1       = add_e.data1[DATA_W-1:0];
    a2       = add_e.data2[DATA_W-1:0];
    sum      = {1'b0, a1} + {1'b0, a2};
    add_resp = RespErr;
    add_data = '0;
    case (add_e.cmd)
      CmdAdd: begin
        if (!sum[DATA_W]) begin
          add_resp = RespOk;
          add_data = sum[DATA_W-1:0];
        end
      end
      CmdSub: begin
        if (a2 <= a1) begin
          add_resp = RespOk;
          add_data = a1 - a2;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    shf_e    = head[shf_idx];
    s1       = shf_e.data1[DATA_W-1:0];
    shamt    = shf_e.data2[ShW-1:0];
    shf_data = (shf_e.cmd == CmdShl) ? (s1 << shamt) : (s1 >> shamt);
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      add_ptr_q <= '0;
      shf_ptr_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        resp_q[p] <= RespNone;
        data_q[p] <= '0;
        tag_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        resp_q[p] <= RespNone;
        data_q[p] <= '0;
        tag_q[p]  <= '0;
      end
      if (add_gnt) begin
        resp_q[add_idx] <= add_resp;
        data_q[add_idx] <= add_data;
        tag_q[add_idx]  <= add_e.tag[TAG_W-1:0];
        add_ptr_q       <= ptr_after(add_idx);
      end
      if (shf_gnt) begin
        resp_q[shf_idx] <= RespOk;
        data_q[shf_idx] <= shf_data;
        tag_q[shf_idx]  <= shf_e.tag[TAG_W-1:0];
        shf_ptr_q       <= ptr_after(shf_idx);
      end
    end
  end

endmodule

// File: tb/tb_calc3_core.sv
// Bench for calc3_core: directed vector table, multi-cycle ordering/overflow/reset sequences,
// and randomized traffic compared every cycle against a transaction-level reference model.
module tb_calc3_core;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int QD = 2;

  logic              c_clk = 1'b0;
  logic              reset;
  logic [NP*4-1:0]   req_cmd_in;
  logic [NP*DW-1:0]  req_data_in;
  logic [NP*TW-1:0]  req_tag_in;
  logic [NP-1:0]     req_busy;
  logic [NP*2-1:0]   out_resp;
  logic [NP*DW-1:0]  out_data;
  logic [NP*TW-1:0]  out_tag;

  logic [3:0]    cmd_a [NP];
  logic [DW-1:0] dat_a [NP];
  logic [TW-1:0] tag_a [NP];

  calc3_core #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .TAG_W     (TW),
    .QDEPTH    (QD)
  ) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .req_tag_in  (req_tag_in),
    .req_busy    (req_busy),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .out_tag     (out_tag)
  );

  always #5 c_clk = ~c_clk;

  always_comb begin
    req_cmd_in  = '0;
    req_data_in = '0;
    req_tag_in  = '0;
    for (int p = 0; p < NP; p++) begin
      req_cmd_in[4*p +: 4]    = cmd_a[p];
      req_data_in[DW*p +: DW] = dat_a[p];
      req_tag_in[TW*p +: TW]  = tag_a[p];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model: per-port command queues ----------------
  typedef struct {
    logic [3:0]    cmd;
    logic [TW-1:0] tag;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } ment_t;

  ment_t         mq [NP][QD];
  int            mcnt [NP];
  bit            mcap [NP];
  ment_t         mcap_e [NP];
  int            mptr [2];
  logic [1:0]    e_resp [NP];
  logic [DW-1:0] e_data [NP];
  logic [TW-1:0] e_tag [NP];

  function automatic int unit_of(input logic [3:0] c);
    return (c == 4'h5 || c == 4'h6) ? 1 : 0;
  endfunction

  task automatic golden(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output logic [1:0] r, output logic [DW-1:0] d);
    longint unsigned wa, wb;
    wa = 64'(a);
    wb = 64'(b);
    r  = 2'b10;
    d  = '0;
    case (c)
      4'h1: if (wa + wb <= 64'hFFFF_FFFF) begin r = 2'b01; d = DW'(wa + wb); end
      4'h2: if (wb <= wa) begin r = 2'b01; d = DW'(wa - wb); end
      4'h5: begin r = 2'b01; d = a << b[4:0]; end
      4'h6: begin r = 2'b01; d = a >> b[4:0]; end
      default: ;
    endcase
  endtask

  task automatic model_clear();
    for (int p = 0; p < NP; p++) begin
      mcnt[p]   = 0;
      mcap[p]   = 0;
      e_resp[p] = '0;
      e_data[p] = '0;
      e_tag[p]  = '0;
    end
    mptr[0] = 0;
    mptr[1] = 0;
  endtask

  task automatic model_edge();
    bit busy [NP];
    int gnt [2];
    if (!reset) begin
      model_clear();
      return;
    end
    for (int p = 0; p < NP; p++) begin
      busy[p]   = (mcnt[p] + int'(mcap[p])) >= QD;
      e_resp[p] = '0;
      e_data[p] = '0;
      e_tag[p]  = '0;
    end
    // Both units look at the heads as they stand before any pop this cycle.
    for (int u = 0; u < 2; u++) begin
      gnt[u] = -1;
      for (int i = 0; i < NP; i++) begin
        int p;
        p = (mptr[u] + i) % NP;
        if (gnt[u] < 0 && mcnt[p] > 0 && unit_of(mq[p][0].cmd) == u) gnt[u] = p;
      end
    end
    for (int u = 0; u < 2; u++) begin
      if (gnt[u] >= 0) begin
        int p;
        p = gnt[u];
        golden(mq[p][0].cmd, mq[p][0].d1, mq[p][0].d2, e_resp[p], e_data[p]);
        e_tag[p] = mq[p][0].tag;
        for (int k = 0; k < QD - 1; k++) mq[p][k] = mq[p][k+1];
        mcnt[p]--;
        mptr[u] = (p + 1) % NP;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (mcap[p]) begin
        mcap_e[p].d2 = dat_a[p];
        if (mcnt[p] < QD) begin
          mq[p][mcnt[p]] = mcap_e[p];
          mcnt[p]++;
        end
        mcap[p] = 0;
      end else if (cmd_a[p] != 4'h0 && !busy[p]) begin
        mcap[p]        = 1;
        mcap_e[p].cmd  = cmd_a[p];
        mcap_e[p].tag  = tag_a[p];
        mcap_e[p].d1   = dat_a[p];
      end
    end
  endtask

  // ---------------- response log ----------------
  typedef struct {
    int            cyc;
    int            port;
    logic [1:0]    r;
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } rec_t;

  rec_t log_q[$];

  task automatic find(input int port, input int c, output bit found, output rec_t r);
    found = 0;
    r = '{default: 0};
    foreach (log_q[k]) begin
      if (log_q[k].cyc == c && log_q[k].port == port) begin
        found = 1;
        r = log_q[k];
      end
    end
  endtask

  function automatic int count_resp(input int port, input int c_lo, input int c_hi);
    int n;
    n = 0;
    foreach (log_q[k]) begin
      if (log_q[k].port == port && log_q[k].cyc >= c_lo && log_q[k].cyc <= c_hi) n++;
    end
    return n;
  endfunction

  // One clock cycle: sample at the falling edge, compare with the model, advance the model.
  task automatic tick();
    logic [NP*2-1:0]  xr;
    logic [NP*DW-1:0] xd;
    logic [NP*TW-1:0] xt;
    logic [NP-1:0]    xb;
    rec_t             rec;
    @(negedge c_clk);
    for (int p = 0; p < NP; p++) begin
      xr[2*p +: 2]   = e_resp[p];
      xd[DW*p +: DW] = e_data[p];
      xt[TW*p +: TW] = e_tag[p];
      xb[p]          = (mcnt[p] + int'(mcap[p])) >= QD;
      if (out_resp[2*p +: 2] != 2'b00) begin
        rec.cyc  = cyc;
        rec.port = p;
        rec.r    = out_resp[2*p +: 2];
        rec.d    = out_data[DW*p +: DW];
        rec.t    = out_tag[TW*p +: TW];
        log_q.push_back(rec);
      end
    end
    check("model_resp", 256'(out_resp), 256'(xr));
    check("model_data", 256'(out_data), 256'(xd));
    check("model_tag",  256'(out_tag),  256'(xt));
    check("model_busy", 256'(req_busy), 256'(xb));
    model_edge();
    @(posedge c_clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    for (int p = 0; p < NP; p++) begin
      cmd_a[p] = '0;
      dat_a[p] = '0;
      tag_a[p] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [DW-1:0] pick_data();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h1;
      3: return 32'h8000_0000;
      4: return DW'($urandom_range(0, 40));
      default: return DW'($urandom);
    endcase
  endfunction

  function automatic logic [3:0] pick_cmd();
    case ($urandom_range(0, 9))
      0, 1: return 4'h1;
      2, 3: return 4'h2;
      4, 5: return 4'h5;
      6, 7: return 4'h6;
      default: return 4'($urandom_range(1, 15));
    endcase
  endfunction

  typedef struct {
    int            port;
    logic [3:0]    cmd;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [TW-1:0] tag;
    logic [1:0]    er;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit   found;
    rec_t r;
    int   t0;

    vecs[0]  = '{0, 4'h1, 32'h0000_0005, 32'h0000_0007, 2'd1, 2'b01, 32'h0000_000C};
    vecs[1]  = '{1, 4'h1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 2'b10, 32'h0000_0000};
    vecs[2]  = '{2, 4'h2, 32'h0000_0003, 32'h0000_0005, 2'd3, 2'b10, 32'h0000_0000};
    vecs[3]  = '{2, 4'h2, 32'h0000_0005, 32'h0000_0003, 2'd0, 2'b01, 32'h0000_0002};
    vecs[4]  = '{1, 4'h1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 2'b01, 32'hFFFF_FFFF};
    vecs[5]  = '{3, 4'h5, 32'h0000_0001, 32'h0000_0024, 2'd2, 2'b01, 32'h0000_0010};
    vecs[6]  = '{0, 4'h6, 32'h8000_0000, 32'h0000_001F, 2'd3, 2'b01, 32'h0000_0001};
    vecs[7]  = '{1, 4'h6, 32'h0000_00F0, 32'h0000_0104, 2'd0, 2'b01, 32'h0000_000F};
    vecs[8]  = '{2, 4'h3, 32'h0000_0010, 32'h0000_0001, 2'd2, 2'b10, 32'h0000_0000};
    vecs[9]  = '{3, 4'hF, 32'h1234_5678, 32'h0000_0000, 2'd1, 2'b10, 32'h0000_0000};
    vecs[10] = '{0, 4'h2, 32'h0000_0007, 32'h0000_0007, 2'd1, 2'b01, 32'h0000_0000};
    vecs[11] = '{3, 4'h5, 32'hFFFF_FFFF, 32'h0000_001F, 2'd3, 2'b01, 32'h8000_0000};

    reset = 1'b0;
    idle();
    model_clear();
    repeat (3) tick();
    check("reset_resp", 256'(out_resp), 256'(0));
    check("reset_data", 256'(out_data), 256'(0));
    check("reset_tag",  256'(out_tag),  256'(0));
    check("reset_busy", 256'(req_busy), 256'(0));
    reset = 1'b1;
    tick();

    // Directed vectors, one at a time on an idle machine; response expected at t+3.
    for (int v = 0; v < 12; v++) begin
      t0 = cyc;
      idle();
      cmd_a[vecs[v].port] = vecs[v].cmd;
      dat_a[vecs[v].port] = vecs[v].d1;
      tag_a[vecs[v].port] = vecs[v].tag;
      tick();
      cmd_a[vecs[v].port] = '0;
      dat_a[vecs[v].port] = vecs[v].d2;
      tick();
      idle();
      repeat (4) tick();
      find(vecs[v].port, t0 + 3, found, r);
      check($sformatf("vec%0d", v), {found, r.r, r.d, r.t},
            {1'b1, vecs[v].er, vecs[v].ed, vecs[v].tag});
    end

    // All ports add together, twice back to back: grant order 0..3 both times.
    do_reset();
    tick();
    t0 = cyc;
    for (int p = 0; p < NP; p++) begin
      cmd_a[p] = 4'h1; dat_a[p] = DW'(p + 1); tag_a[p] = TW'(p);
    end
    tick();
    for (int p = 0; p < NP; p++) begin cmd_a[p] = '0; dat_a[p] = 32'd10; end
    tick();
    for (int p = 0; p < NP; p++) begin
      cmd_a[p] = 4'h1; dat_a[p] = DW'(p + 100); tag_a[p] = TW'(3 - p);
    end
    tick();
    for (int p = 0; p < NP; p++) begin cmd_a[p] = '0; dat_a[p] = 32'd1; end
    tick();
    idle();
    repeat (12) tick();
    for (int p = 0; p < NP; p++) begin
      find(p, t0 + 3 + p, found, r);
      check($sformatf("rr_first_p%0d", p), {found, r.r, r.d, r.t},
            {1'b1, 2'b01, DW'(p + 11), TW'(p)});
      find(p, t0 + 7 + p, found, r);
      check($sformatf("rr_second_p%0d", p), {found, r.r, r.d, r.t},
            {1'b1, 2'b01, DW'(p + 101), TW'(3 - p)});
    end

    // Shift on port3 and add on port0 proceed in parallel.
    t0 = cyc;
    cmd_a[3] = 4'h5; dat_a[3] = 32'h1; tag_a[3] = 2'd2;
    cmd_a[0] = 4'h1; dat_a[0] = 32'h2; tag_a[0] = 2'd1;
    tick();
    cmd_a[3] = '0; dat_a[3] = 32'h24;
    cmd_a[0] = '0; dat_a[0] = 32'h3;
    tick();
    idle();
    repeat (4) tick();
    find(3, t0 + 3, found, r);
    check("par_shift", {found, r.r, r.d, r.t}, {1'b1, 2'b01, 32'h10, 2'd2});
    find(0, t0 + 3, found, r);
    check("par_add", {found, r.r, r.d, r.t}, {1'b1, 2'b01, 32'h5, 2'd1});

    // FIFO full on port0 while other ports hold the add unit: third command is dropped.
    do_reset();
    t0 = cyc;
    cmd_a[0] = 4'h1; dat_a[0] = 32'd1; tick();
    cmd_a[0] = '0;   dat_a[0] = 32'd1; tick();
    cmd_a[0] = 4'h1; dat_a[0] = 32'd2;
    cmd_a[1] = 4'h1; dat_a[1] = 32'd5;
    cmd_a[2] = 4'h1; dat_a[2] = 32'd6;
    tick();
    idle();
    dat_a[0] = 32'd2; dat_a[1] = 32'd5; dat_a[2] = 32'd6;
    tick();
    idle();
    cmd_a[0] = 4'h1; dat_a[0] = 32'd3; tick();
    cmd_a[0] = '0;   dat_a[0] = 32'd3; tick();
    check("busy_full", 256'(req_busy[0]), 256'(1));
    cmd_a[0] = 4'h1; dat_a[0] = 32'd4; tick();
    cmd_a[0] = '0;   dat_a[0] = 32'd4; tick();
    idle();
    repeat (10) tick();
    check("drop_count", 256'(count_resp(0, t0, cyc)), 256'(3));

    // Reset mid-burst discards queued and half-captured commands.
    for (int p = 0; p < NP; p++) begin cmd_a[p] = 4'h1; dat_a[p] = 32'd7; end
    tick();
    for (int p = 0; p < NP; p++) begin cmd_a[p] = '0; end
    tick();
    for (int p = 0; p < NP; p++) begin cmd_a[p] = 4'h2; dat_a[p] = 32'd9; end
    tick();
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
    check("rst_mid_resp", 256'(out_resp), 256'(0));
    check("rst_mid_data", 256'(out_data), 256'(0));
    check("rst_mid_tag",  256'(out_tag),  256'(0));
    check("rst_mid_busy", 256'(req_busy), 256'(0));
    t0 = cyc;
    repeat (12) tick();
    begin
      int n;
      n = 0;
      for (int p = 0; p < NP; p++) n += count_resp(p, t0, cyc);
      check("rst_mid_silence", 256'(n), 256'(0));
    end

    // Randomized traffic, including occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      for (int p = 0; p < NP; p++) begin
        cmd_a[p] = ($urandom_range(0, 2) == 0) ? pick_cmd() : 4'h0;
        dat_a[p] = pick_data();
        tag_a[p] = TW'($urandom);
      end
      tick();
    end
    reset = 1'b1;
    idle();
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
